count7_rr_scheduler: RTL
========================

Name: count7_rr_scheduler

Overview:
Time-slot scheduler that shares one 7-bit down-counter timebase among up to four requesters.
- Arbitrates pending requests round-robin.
- Loads the winner's 7-bit period into an internal down-counter, counts to zero and signals slot completion to the owner.
- Inserts a programmable guard gap between slots.
- Sits between UDB-side requesters, such as PWM/pulse generators, and the shared count7-style timebase it owns.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..4.
GAP_CYCLES, 1, enabled cycles of guard gap after each slot; legal range 0..15.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
en  input  1  count enable; gates RUN and GAP progress only, not arbitration.
req  input  NUM_REQ  level request per requester.
period  input  7*NUM_REQ  requester i period at bits [7i+6:7i]; sampled only on grant.
abort  input  1  cancels the current slot.
grant  output  NUM_REQ  one-hot owner of the timebase, registered; all-zero when no owner.
cnt  output  7  current counter value.
tc  output  1  terminal count, combinational.
done  output  NUM_REQ  one-cycle completion pulse to the owner, combinational.
busy  output  1  high whenever state is not ARB.

Behaviour:
- Reset values, asynchronous on reset=0:
  - state=ARB, grant=0, cnt=0, gap counter=0.
  - rr pointer=NUM_REQ-1, so requester 0 wins first.
  - tc=0, done=0, busy=0.
- States: ARB, RUN, GAP.
- ARB:
  - If any req bit is high, pick the first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Next edge: grant<=onehot(winner), cnt<=period[winner], pointer<=winner, state<=RUN.
  - If no request, stay in ARB with grant=0.
  - Arbitration ignores en.
- RUN:
  - tc = (state==RUN) & en & (cnt==0).
  - en=1, cnt!=0: cnt decrements by 1.
  - en=0: cnt holds; no tc.
  - tc=1:
    - done = grant for that cycle.
    - Next edge: grant<=0, cnt stays 0.
    - state<=GAP with gap counter=GAP_CYCLES, or state<=ARB if GAP_CYCLES=0.
  - abort=1 with tc=0: no tc, no done; next edge grant<=0, cnt<=0, state<=GAP or ARB as above.
  - abort and tc in the same cycle: tc wins; the slot completes normally and done pulses.
  - Owner dropping req during RUN is ignored; the slot runs to completion or abort.
  - period changes during RUN are ignored.
- Slot length: period P gives P+1 enabled RUN cycles, cnt showing P, P-1, ..., 0. P=0 gives a one-cycle slot; tc fires in the first RUN cycle if en=1.
- GAP:
  - grant=0, cnt=0.
  - Gap counter decrements on cycles with en=1.
  - Next edge after the cycle in which it reads 1 with en=1: state<=ARB.
- Latency, en held high:
  - req at cycle k in ARB → grant at k+1.
  - tc at k+1+P.
  - grant low at k+2+P.
  - ARB re-entered at k+2+P+GAP_CYCLES.
  - Next grant at k+3+P+GAP_CYCLES.
- Fairness: after requester i completes, any other pending requester beats i.
- Reset asserted mid-slot: immediate return to reset values; no done is issued.
- tc and done are never high outside RUN; grant is at most one-hot at all times.

Test Plan:
1. Basic slot: reset release; NUM_REQ=4, GAP=1, en=1; req=4'b0001, period0=5 at cycle 0 → grant=0001 at cycle 1; cnt 5..0 over cycles 1-6; tc and done[0] at cycle 6; grant=0 at 7; next grant at cycle 9 if req held.
2. Round-robin: req=4'b1011 held, all periods=2, GAP=0 → grant order 0001, 0010, 1000, 0001; each slot 3 RUN cycles + 1 ARB cycle.
3. Enable stall: period=3; en low for 4 cycles while cnt=2 → cnt holds 2, tc stays 0; completion delayed exactly 4 cycles.
4. Abort vs tc: abort at cnt=4 → no tc/done, grant drops next cycle. abort at cnt=0 with en=1 → tc=1 and done pulses.
5. Boundaries:
   - period=0 → one-cycle slot with tc in the first RUN cycle.
   - period=127 → 128 RUN cycles; cnt starts at 7'h7F, with no wrap below 0.
6. Async reset: reset=0 mid-RUN at cnt=40 → grant=0, cnt=0, busy=0 immediately without waiting for a clock edge. After release with req=4'b1100 → requester 2 wins first.

Source files
------------

// File: rtl/count7_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// count7_rr_scheduler_if
// Bundle between the requesters (master) and the shared count7 timebase
// scheduler (slave).
//   en     : count enable (stalls RUN/GAP progress, never arbitration)
//   req    : level request, one bit per requester
//   period : 7-bit slot period per requester, requester i at [7i+6:7i]
//   abort  : cancel the slot currently running
//   grant  : one-hot owner of the timebase (registered), zero when idle
//   cnt    : current down-counter value
//   tc     : terminal count of the running slot
//   done   : one-cycle completion pulse routed to the owner
//   busy   : scheduler is running a slot or a guard gap
// ---------------------------------------------------------------------------
interface count7_rr_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic                   en;
  logic [NUM_REQ-1:0]     req;
  logic [7*NUM_REQ-1:0]   period;
  logic                   abort;
  logic [NUM_REQ-1:0]     grant;
  logic [6:0]             cnt;
  logic                   tc;
  logic [NUM_REQ-1:0]     done;
  logic                   busy;

  modport master (
    output en, req, period, abort,
    input  grant, cnt, tc, done, busy
  );

  modport slave (
    input  en, req, period, abort,
    output grant, cnt, tc, done, busy
  );
endinterface

// File: rtl/count7_rr_scheduler.sv
// ---------------------------------------------------------------------------
// count7_rr_scheduler
// Shares one 7-bit down-counter timebase among NUM_REQ requesters. Pending
// requests are arbitrated round-robin; the winner's period is loaded into
// the counter, which counts down to zero on enabled cycles. Terminal count
// pulses done to the owner, then an optional guard gap of GAP_CYCLES
// enabled cycles separates consecutive slots.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of count7_rr_scheduler_if (en/req/period/abort in,
//           grant/cnt/tc/done/busy out)
// ---------------------------------------------------------------------------
module count7_rr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  count7_rr_scheduler_if.slave bus
);

  localparam int PW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    ARB = 2'd0,
    RUN = 2'd1,
    GAP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [6:0]         cnt_q,   cnt_d;
  logic [3:0]         gap_q,   gap_d;
  logic [PW-1:0]      ptr_q,   ptr_d;

  logic               any_req_s;
  logic [PW-1:0]      winner_s;
  logic [6:0]         win_period_s;
  logic               tc_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin search starting just after the last owner. The loop runs
  // from the farthest offset to the nearest so the nearest hit is kept.
  always_comb begin
    int idx;
    idx          = 0;
    any_req_s    = 1'b0;
    winner_s     = ptr_q;
    win_period_s = 7'd0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (bus.req[idx]) begin
        any_req_s    = 1'b1;
        winner_s     = PW'(idx);
        win_period_s = bus.period[7*idx +: 7];
      end else begin
        any_req_s    = any_req_s;
      end
    end
  end

  // Terminal count only exists for an enabled RUN cycle at zero.
  assign tc_s = (state_q == RUN) && bus.en && (cnt_q == 7'd0);

  // Next-state logic for the ARB -> RUN -> GAP -> ARB slot cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB: begin
        if (any_req_s) begin
          state_d = RUN;
          grant_d = onehot(winner_s);
          cnt_d   = win_period_s;
          ptr_d   = winner_s;
        end else begin
          grant_d = '0;
        end
      end
      RUN: begin
        // tc and abort end the slot identically; only done tells them apart.
        if (tc_s || bus.abort) begin
          grant_d = '0;
          cnt_d   = 7'd0;
          if (GAP_CYCLES == 0) begin
            state_d = ARB;
            gap_d   = 4'd0;
          end else begin
            state_d = GAP;
            gap_d   = 4'(GAP_CYCLES);
          end
        end else if (bus.en) begin
          cnt_d = cnt_q - 7'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      GAP: begin
        grant_d = '0;
        cnt_d   = 7'd0;
        if (bus.en) begin
          gap_d = gap_q - 4'd1;
          // <= 1 also recovers from a zero gap count instead of wrapping.
          if (gap_q <= 4'd1) begin
            state_d = ARB;
            gap_d   = 4'd0;
          end else begin
            state_d = GAP;
          end
        end else begin
          gap_d = gap_q;
        end
      end
      default: begin
        state_d = ARB;
        grant_d = '0;
        cnt_d   = 7'd0;
        gap_d   = 4'd0;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ARB;
      grant_q <= '0;
      cnt_q   <= 7'd0;
      gap_q   <= 4'd0;
      ptr_q   <= PW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.cnt   = cnt_q;
  assign bus.tc    = tc_s;
  assign bus.done  = tc_s ? grant_q : '0;
  assign bus.busy  = (state_q != ARB);

endmodule
